scan_position_counter: RTL and testbench

- Two-level pixel/line position counter; parametrised successor to the single-shot global counter.
- Pixel counter restarts on a line sync pulse (HSYNC-derived). Its first increment after a restart jumps by START, then it counts by 1.
- Line counter advances on each completed line and wraps at a frame boundary.
- Supports one-shot (stop at terminal count) and free-run (wrap) modes, a count enable, and registered line/frame completion pulses for downstream shift-register and pixel logic.

---
 rtl/scan_position_counter.sv | 116 +++++++++++
 tb/tb_scan_position_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_position_counter.sv
// Two-level pixel/line position counter with one-shot and free-run modes.
// Line and frame completion are reported as registered single-cycle pulses.
module scan_position_counter #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned LWIDTH    = 10,
    parameter int unsigned START     = 2,
    parameter int unsigned PIX_LAST  = 2**DWIDTH - 1,
    parameter int unsigned LINE_LAST = 2**LWIDTH - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              frame_sync,
    input  logic              en,
    input  logic              oneshot,
    output logic [DWIDTH-1:0] counter,
    output logic [LWIDTH-1:0] line,
    output logic              running,
    output logic              line_done,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] PL  = DWIDTH'(PIX_LAST);
    localparam logic [DWIDTH-1:0] ST  = DWIDTH'(START);
    localparam logic [LWIDTH-1:0] LL  = LWIDTH'(LINE_LAST);

    state_t            state;
    state_t            state_n;
    logic [DWIDTH-1:0] cnt_n;
    logic [LWIDTH-1:0] line_n;
    logic              ld_n;
    logic              fd_n;
    logic              pix_last;
    logic              line_last;

    assign pix_last  = (counter == PL);
    assign line_last = (line == LL);

    // State, counters and completion pulses; active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            line       <= '0;
            running    <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            counter    <= cnt_n;
            line       <= line_n;
            running    <= (state_n == RUN);
            line_done  <= ld_n;
            frame_done <= fd_n;
        end
    end

    // Next-state decode: frame_sync beats sync, both beat counting
    always_comb begin
        state_n = state;
        cnt_n   = counter;
        line_n  = line;
        ld_n    = 1'b0;
        fd_n    = 1'b0;
        if (frame_sync) begin
            state_n = RUN;
            cnt_n   = '0;
            line_n  = '0;
        end else if (sync) begin
            state_n = RUN;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                RUN: begin
                    if (en) begin
                        if (counter == '0) begin
                            cnt_n = ST;
                        end else if (pix_last) begin
                            ld_n = 1'b1;
                            if (line_last) begin
                                line_n = '0;
                                fd_n   = 1'b1;
                            end else begin
                                line_n = line + 1'b1;
                            end
                            if (oneshot) begin
                                state_n = HOLD;
                                cnt_n   = PL;
                            end else begin
                                cnt_n = '0;
                            end
                        end else begin
                            cnt_n = counter + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    cnt_n = PL;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_position_counter.sv
// Bench for scan_position_counter: directed vector table, a hand sequence
// for one-shot frame end, and random stimulus against a position model.
module tb_scan_position_counter;

    localparam int DW = 4;
    localparam int LW = 2;
    localparam int ST = 2;
    localparam int PL = 15;
    localparam int LL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync;
    logic          frame_sync;
    logic          en;
    logic          oneshot;
    logic [DW-1:0] counter;
    logic [LW-1:0] line;
    logic          running;
    logic          line_done;
    logic          frame_done;

    always #5 clk = ~clk;

    scan_position_counter #(
        .DWIDTH(DW), .LWIDTH(LW), .START(ST),
        .PIX_LAST(PL), .LINE_LAST(LL)
    ) dut (
        .clk(clk), .rst(rst), .sync(sync),
        .frame_sync(frame_sync), .en(en), .oneshot(oneshot),
        .counter(counter), .line(line), .running(running),
        .line_done(line_done), .frame_done(frame_done)
    );

    typedef struct {
        logic r, fs, sy, e, o;
        int   cnt, ln;
        logic run, ld, fd;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // model: enabled steps since line restart, not a counter value
    int   m_steps = 0;
    int   m_line  = 0;
    bit   m_act   = 0;
    bit   m_held  = 0;
    bit   m_ld    = 0;
    bit   m_fd    = 0;

    function automatic int m_pos();
        if (m_held) return PL;
        if (m_steps == 0) return 0;
        return ST + m_steps - 1;
    endfunction

    function automatic void model_step(logic r, logic fs, logic sy,
                                       logic e, logic o);
        int pos;
        pos  = m_pos();
        m_ld = 0;
        m_fd = 0;
        if (!r) begin
            m_steps = 0; m_line = 0; m_act = 0; m_held = 0;
        end else if (fs) begin
            m_steps = 0; m_line = 0; m_act = 1; m_held = 0;
        end else if (sy) begin
            m_steps = 0; m_act = 1; m_held = 0;
        end else if (m_act && e) begin
            if (pos == PL) begin
                m_ld = 1;
                if (m_line == LL) begin
                    m_line = 0;
                    m_fd   = 1;
                end else begin
                    m_line = m_line + 1;
                end
                if (o) begin
                    m_act  = 0;
                    m_held = 1;
                end else begin
                    m_steps = 0;
                end
            end else begin
                m_steps = m_steps + 1;
            end
        end
    endfunction

    function automatic void add(logic r, logic fs, logic sy, logic e,
                                logic o, int c, int l, logic run,
                                logic ld, logic fd);
        vec_t v;
        v.r = r; v.fs = fs; v.sy = sy; v.e = e; v.o = o;
        v.cnt = c; v.ln = l; v.run = run; v.ld = ld; v.fd = fd;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic apply(logic r, logic fs, logic sy, logic e, logic o);
        rst = r; frame_sync = fs; sync = sy; en = e; oneshot = o;
        @(posedge clk);
        model_step(r, fs, sy, e, o);
        #1;
    endtask

    task automatic chk_all(string tag, int c, int l, logic run,
                           logic ld, logic fd);
        chk({tag, " cnt"}, 32'(counter), 32'(c));
        chk({tag, " line"}, 32'(line), 32'(l));
        chk({tag, " run"}, 32'(running), 32'(run));
        chk({tag, " ld"}, 32'(line_done), 32'(ld));
        chk({tag, " fd"}, 32'(frame_done), 32'(fd));
    endtask

    initial begin
        rst = 1'b0; sync = 1'b0; frame_sync = 1'b0;
        en = 1'b0; oneshot = 1'b0;

        // reset, then idle with enable and no sync
        repeat (2) add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // one-shot line: 0,2..15 then HOLD
        add(1, 0, 1, 1, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 14; k++)
            add(1, 0, 0, 1, 1, k + 1, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 15, 1, 0, 1, 0);
        repeat (10) add(1, 0, 0, 1, 1, 15, 1, 0, 0, 0);
        // frame_sync out of HOLD, then three free-run lines
        add(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int l = 0; l < 3; l++) begin
            for (int k = 1; k <= 15; k++) begin
                if (k < 15)
                    add(1, 0, 0, 1, logic'((l == 0) && (k % 2 == 1)),
                        k + 1, l, 1, 0, 0);
                else
                    add(1, 0, 0, 1, 0, 0, (l + 1) % 3, 1, 1,
                        logic'(l == 2));
            end
        end
        // stall at 7
        for (int k = 1; k <= 6; k++)
            add(1, 0, 0, 1, 0, k + 1, 0, 1, 0, 0);
        repeat (4) add(1, 0, 0, 0, 0, 7, 0, 1, 0, 0);
        for (int c = 8; c <= 15; c++)
            add(1, 0, 0, 1, 0, c, 0, 1, 0, 0);
        // sync at PIX_LAST wins over completion
        add(1, 0, 1, 1, 1, 0, 0, 1, 0, 0);
        // advance to line 1, counter 9, then reset mid-line
        for (int k = 1; k <= 14; k++)
            add(1, 0, 0, 1, 0, k + 1, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 1, 1, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 0, 0, 1, 0, k + 1, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 2, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].fs, tbl[i].sy, tbl[i].e, tbl[i].o);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ln,
                    tbl[i].run, tbl[i].ld, tbl[i].fd);
        end

        // one-shot completion of the last line of a frame
        apply(1, 1, 0, 1, 0);
        repeat (44) apply(1, 0, 0, 1, 0);
        chk_all("osf pre", 15, 2, 1, 0, 0);
        apply(1, 0, 0, 1, 1);
        chk_all("osf end", 15, 0, 0, 1, 1);
        apply(1, 0, 0, 1, 0);
        chk_all("osf hold", 15, 0, 0, 0, 0);

        // random stimulus against the model
        apply(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            apply(logic'($urandom_range(0, 199) != 0),
                  logic'($urandom_range(0, 99) < 2),
                  logic'($urandom_range(0, 99) < 3),
                  logic'($urandom_range(0, 99) < 80),
                  logic'($urandom_range(0, 1)));
            chk_all($sformatf("rnd%0d", i), m_pos(), m_line,
                    m_act, m_ld, m_fd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
